ram64_stream_reader: RTL and testbench
======================================

// Module: ram64_stream_reader
// PURPOSE
// - Reader for the 64x20 sample RAM: scans a window of entries at a programmed rate and streams them out.
// - Drives the RAM select with LOAD held low and captures the RAM output.
// - Presents each sample on a valid/ready handshake to the downstream voice/DAC path.
// - Sits between the RAM64 store and the synth output stage; supports one-shot and looped playback.
// PARAMETERS
// - RD_LAT  1   cycles from ram_sel change to valid ram_out (1..3)
// - DW      20  sample width, matches RAM word
// - AW      6   RAM address width (64 entries)
// PORTS
// - clk           in   1   single clock; all logic on rising edge
// - rst           in   1   asynchronous, active-high reset
// - start         in   1   begin playback (sampled only in IDLE)
// - stop          in   1   abort playback, any state
// - loop          in   1   latched at start: 1 = wrap to first entry after last
// - base_addr     in   6   first RAM entry, latched at start
// - length        in   7   entries to play, 1..64; 0 = empty run, latched at start
// - period        in   16  min cycles between fetch starts; 0 treated as 1; latched at start
// - ram_sel       out  6   RAM select
// - ram_load      out  1   RAM write enable; constant 0
// - ram_out       in   20  RAM read data
// - sample        out  20  captured sample
// - sample_valid  out  1   sample holds valid data
// - sample_ready  in   1   downstream accepts sample
// - busy          out  1   high in any state except IDLE
// - done          out  1   one-cycle pulse at end of a one-shot run
// - underrun      out  1   sticky: a fetch was delayed by backpressure; cleared by start
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; ram_sel=0, ram_load=0, sample=0, sample_valid=0, busy=0, done=0, underrun=0; idx and timer=0.
// - States: IDLE -> FETCH -> WAIT -> HOLD -> (FETCH | DONE | IDLE).
// - IDLE: on start && !stop: latch inputs, clear underrun, idx=0, timer=0.
//   - length!=0 -> FETCH.
//   - length==0 -> DONE.
// - FETCH (1 cycle):
//   - ram_sel = (base_addr + idx) mod 64; wraps 63 -> 0.
//   - timer restarts at period.
// - WAIT: hold ram_sel for RD_LAT cycles, then sample <= ram_out, sample_valid=1 -> HOLD.
// - HOLD: sample and sample_valid stable until sample_valid && sample_ready.
//   - On that cycle, sample_valid drops next cycle.
//   - idx+1; if idx+1==length: idx=0, loop ? continue : DONE.
// - Next FETCH occurs when the handshake is complete and timer has expired.
//   - Timer decrements every cycle from FETCH and never goes below 0.
//   - Fetch start interval = max(period, RD_LAT+2 + handshake wait).
//   - Set underrun if the handshake completes after the timer has expired.
// - DONE: done=1 for exactly one cycle -> IDLE. Loop runs never pulse done.
// - stop, any non-IDLE state: next cycle IDLE, sample_valid=0, no done pulse; sample keeps last value.
// - stop has priority over start and over a same-cycle handshake; the dropped sample is not counted.
// - start while busy: ignored.
// - ram_sel holds its last value in IDLE.
// - Input changes mid-run have no effect until the next start.
// TESTING
// - Reset mid-HOLD, sample_valid=1: all outputs 0 within the same cycle; busy=0.
// - Preload RAM[i]=i; base=0, length=4, period=8, ready=1, loop=0:
//   - samples 0,1,2,3; valid edges 8 cycles apart;
//   - one done pulse; underrun=0.
// - base=62, length=4: ram_sel sequence 62,63,0,1; samples 62,63,0,1.
// - loop=1, length=3, base=10: samples 10,11,12,10,11,12...; no done pulse.
//   - stop during 2nd HOLD: valid drops next cycle; IDLE; no done.
// - period=2, ready low 20 cycles on the 1st sample:
//   - sample stays 0 and valid stays high for those 20 cycles;
//   - underrun=1; next fetch on the cycle after the handshake.
// - length=0 start: done pulse 1 cycle later; no sample_valid.
//   - start asserted while busy: no restart.

Source files
------------

// File: rtl/ram64_stream_reader.sv
// Streams a programmed window of the 64-entry sample RAM out over a valid/ready handshake.
// Fetches are paced by a period timer and can run once or loop until stopped.
module ram64_stream_reader #(
    parameter int RD_LAT = 1,
    parameter int DW     = 20,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic [15:0]   period,
    output logic [AW-1:0] ram_sel,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          loop_q, loop_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   length_q, length_d;
    logic [15:0]   period_q, period_d;
    logic [AW:0]   idx_q, idx_d;
    logic [15:0]   timer_q, timer_d;
    logic [1:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] ram_sel_q, ram_sel_d;
    logic [DW-1:0] sample_q, sample_d;
    logic          sample_valid_q, sample_valid_d;
    logic          underrun_q, underrun_d;
    logic          stall_q, stall_d;

    logic          handshake;
    logic          timer_ready;
    logic          fetch_go;
    logic          last;
    logic [AW:0]   idx_inc;
    logic [15:0]   period_eff;

    assign period_eff  = (period == 16'd0) ? 16'd1 : period;
    assign handshake   = sample_valid_q && sample_ready;
    // The timer reaches zero on the next cycle, so a FETCH entered now lands on the expiry.
    assign timer_ready = (timer_q <= 16'd1);
    assign idx_inc     = idx_q + 1'b1;
    assign last        = (idx_inc == length_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        loop_d         = loop_q;
        base_d         = base_q;
        length_d       = length_q;
        period_d       = period_q;
        idx_d          = idx_q;
        timer_d        = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
        wait_cnt_d     = wait_cnt_q;
        ram_sel_d      = ram_sel_q;
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;
        underrun_d     = underrun_q;
        stall_d        = stall_q;
        fetch_go       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    loop_d     = loop;
                    base_d     = base_addr;
                    length_d   = length;
                    period_d   = period_eff;
                    underrun_d = 1'b0;
                    idx_d      = '0;
                    timer_d    = 16'd0;
                    if (length != '0) begin
                        state_d   = S_FETCH;
                        ram_sel_d = base_addr;
                        timer_d   = period_eff;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                wait_cnt_d = '0;
                stall_d    = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == 2'(RD_LAT - 1)) begin
                    sample_d       = ram_out;
                    sample_valid_d = 1'b1;
                    state_d        = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    sample_valid_d = 1'b0;
                    // Late only if downstream stalled us past the point the timer allowed a fetch.
                    if (stall_q && timer_q == 16'd0) begin
                        underrun_d = 1'b1;
                    end
                    idx_d = last ? '0 : idx_inc;
                    if (last && !loop_q) begin
                        state_d = S_DONE;
                    end else if (timer_ready) begin
                        fetch_go = 1'b1;
                    end
                end else if (sample_valid_q) begin
                    stall_d = 1'b1;
                end else if (timer_ready) begin
                    fetch_go = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fetch_go) begin
            state_d   = S_FETCH;
            ram_sel_d = base_q + idx_d[AW-1:0];
            timer_d   = period_q;
        end

        // Abort wins over everything, including a handshake landing in the same cycle.
        if (stop && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            sample_valid_d = 1'b0;
            sample_d       = sample_q;
            ram_sel_d      = ram_sel_q;
            underrun_d     = underrun_q;
            idx_d          = idx_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            loop_q         <= 1'b0;
            base_q         <= '0;
            length_q       <= '0;
            period_q       <= '0;
            idx_q          <= '0;
            timer_q        <= '0;
            wait_cnt_q     <= '0;
            ram_sel_q      <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            loop_q         <= loop_d;
            base_q         <= base_d;
            length_q       <= length_d;
            period_q       <= period_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            wait_cnt_q     <= wait_cnt_d;
            ram_sel_q      <= ram_sel_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            stall_q        <= stall_d;
        end
    end

    assign ram_sel      = ram_sel_q;
    assign ram_load     = 1'b0;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_ram64_stream_reader.sv
// Scoreboard bench for ram64_stream_reader: directed runs push expected samples,
// a negedge monitor pops and compares on every accepted handshake.
module tb_ram64_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop;
    logic [5:0]  base_addr;
    logic [6:0]  length;
    logic [15:0] period;
    logic [5:0]  ram_sel;
    logic        ram_load;
    logic [19:0] ram_out;
    logic [19:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic        underrun;

    ram64_stream_reader #(.RD_LAT(1), .DW(20), .AW(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .base_addr    (base_addr),
        .length       (length),
        .period       (period),
        .ram_sel      (ram_sel),
        .ram_load     (ram_load),
        .ram_out      (ram_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Sample RAM model: one-cycle synchronous read, RAM[i] = i.
    logic [19:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 20'(i);
    always @(posedge clk) ram_out <= mem[ram_sel];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic prev_valid = 1'b0;
    logic [19:0] exp_q [$];
    int          rise_q [$];
    logic [5:0]  sel_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: handshake completes on the coming posedge unless stop aborts it.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (sample_valid && !prev_valid) begin
                rise_q.push_back(cyc);
                sel_q.push_back(ram_sel);
            end
            if (sample_valid && sample_ready && !stop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d expected none", sample);
                end else begin
                    check("sample", sample, exp_q.pop_front());
                end
                hs_cnt++;
            end
        end
        prev_valid = sample_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic run_start(input logic [5:0] b, input logic [6:0] l, input logic [15:0] p,
                             input logic lp);
        @(posedge clk); #1;
        base_addr = b;
        length    = l;
        period    = p;
        loop      = lp;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (hs_cnt >= target), 1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!sample_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, sample_valid, 1);
    endtask

    initial begin
        int d0;
        int hs0;
        int r0;
        int n;
        int bad;

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        base_addr = '0; length = '0; period = '0; sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ram_sel", ram_sel, 0);
        check("rst_ram_load", ram_load, 0);
        check("rst_sample", sample, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // One-shot, base 0, length 4, period 8.
        sample_ready = 1'b1;
        d0 = done_cnt;
        rise_q.delete();
        exp_q.push_back(20'd0); exp_q.push_back(20'd1);
        exp_q.push_back(20'd2); exp_q.push_back(20'd3);
        run_start(6'd0, 7'd4, 16'd8, 1'b0);
        wait_idle("basic_finish", 200);
        check("basic_done_pulses", done_cnt - d0, 1);
        check("basic_underrun", underrun, 0);
        check("basic_valid_count", rise_q.size(), 4);
        for (int i = 1; i < 4 && i < rise_q.size(); i++)
            check("basic_valid_spacing", rise_q[i] - rise_q[i-1], 8);
        check("basic_queue_drained", exp_q.size(), 0);

        // Address wrap 63 -> 0.
        d0 = done_cnt;
        sel_q.delete();
        exp_q.push_back(20'd62); exp_q.push_back(20'd63);
        exp_q.push_back(20'd0);  exp_q.push_back(20'd1);
        run_start(6'd62, 7'd4, 16'd1, 1'b0);
        wait_idle("wrap_finish", 200);
        check("wrap_done_pulses", done_cnt - d0, 1);
        check("wrap_sel_count", sel_q.size(), 4);
        if (sel_q.size() == 4) begin
            check("wrap_sel0", sel_q[0], 62);
            check("wrap_sel1", sel_q[1], 63);
            check("wrap_sel2", sel_q[2], 0);
            check("wrap_sel3", sel_q[3], 1);
        end

        // Looped run 10,11,12 repeating, then stop between samples.
        d0 = done_cnt;
        hs0 = hs_cnt;
        exp_q.push_back(20'd10); exp_q.push_back(20'd11); exp_q.push_back(20'd12);
        exp_q.push_back(20'd10); exp_q.push_back(20'd11); exp_q.push_back(20'd12);
        exp_q.push_back(20'd10);
        run_start(6'd10, 7'd3, 16'd4, 1'b1);
        wait_hs("loop_progress", hs0 + 7, 300);
        #1;
        stop = 1'b1;
        sample_ready = 1'b0;
        @(posedge clk); #1;
        stop = 1'b0;
        check("loop_stop_busy", busy, 0);
        check("loop_no_done", done_cnt - d0, 0);
        check("loop_queue_drained", exp_q.size(), 0);

        // Looped run, stop while the 2nd sample is held.
        d0 = done_cnt;
        hs0 = hs_cnt;
        sample_ready = 1'b1;
        exp_q.push_back(20'd10);
        run_start(6'd10, 7'd3, 16'd4, 1'b1);
        wait_hs("loop2_first", hs0 + 1, 50);
        #1;
        sample_ready = 1'b0;
        wait_valid("loop2_second_valid", 50);
        check("loop2_second_sample", sample, 11);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("loop2_valid_dropped", sample_valid, 0);
        check("loop2_idle", busy, 0);
        check("loop2_sample_kept", sample, 11);
        repeat (3) @(posedge clk);
        #1;
        check("loop2_no_done", done_cnt - d0, 0);

        // Backpressure: period 2, ready low for 20 cycles on the first sample.
        d0 = done_cnt;
        exp_q.push_back(20'd0); exp_q.push_back(20'd1);
        run_start(6'd0, 7'd2, 16'd2, 1'b0);
        wait_valid("stall_first_valid", 20);
        bad = 0;
        repeat (20) begin
            if (!sample_valid || sample != 20'd0) bad++;
            @(posedge clk); #1;
        end
        check("stall_hold_stable", bad, 0);
        sample_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_underrun", underrun, 1);
        n = 0;
        while (!sample_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_refetch_latency", n, 2);
        wait_idle("stall_finish", 50);
        check("stall_done_pulses", done_cnt - d0, 1);

        // Empty run: done one cycle after start, no sample; start clears underrun.
        d0 = done_cnt;
        r0 = rise_q.size();
        run_start(6'd5, 7'd0, 16'd3, 1'b0);
        check("empty_done", done, 1);
        check("empty_underrun_cleared", underrun, 0);
        @(posedge clk); #1;
        check("empty_done_one_cycle", done, 0);
        check("empty_idle", busy, 0);
        check("empty_no_valid", rise_q.size() - r0, 0);
        check("empty_done_pulses", done_cnt - d0, 1);

        // start (with different inputs) while busy must not restart the run.
        d0 = done_cnt;
        exp_q.push_back(20'd20); exp_q.push_back(20'd21);
        run_start(6'd20, 7'd2, 16'd8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        base_addr = 6'd40;
        length    = 7'd1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("busy_start_finish", 100);
        check("busy_start_done_pulses", done_cnt - d0, 1);
        check("busy_start_queue_drained", exp_q.size(), 0);

        // Asynchronous reset while a sample is held.
        sample_ready = 1'b0;
        run_start(6'd5, 7'd4, 16'd8, 1'b0);
        wait_valid("rstmid_valid", 20);
        check("rstmid_pre_sample", sample, 5);
        rst = 1'b1;
        #1;
        check("rstmid_valid", sample_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_sample", sample, 0);
        check("rstmid_ram_sel", ram_sel, 0);
        check("rstmid_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
